// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction-fetch stage: PC register, IM initiator, F/D pipeline register
// Owns PC sequencing (stall/redirect/sequential) and the F/D latch with flush-to-bubble.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] PC,
  input  logic [31:0] IM_OUT,
  output logic [31:0] D_INSTR,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8,
  output logic        D_VALID,
  output logic [31:0] FETCH_CNT
);

  logic fd_load;
  assign fd_load = !FLUSH && !STALL;

  // A redirect arriving during a stall is dropped; decode keeps presenting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= RESET_PC;
    end else if (!STALL) begin
      if (REDIRECT) begin
        PC <= {REDIRECT_PC[31:2], 2'b00};
      end else begin
        PC <= PC + 32'd4;
      end
    end
  end

  // Flush wins over stall so a stalled slot can still be turned into a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      D_INSTR   <= NOP_INSTR;
      D_PC      <= 32'd0;
      D_PC8     <= 32'd0;
      D_VALID   <= 1'b0;
      FETCH_CNT <= 32'd0;
    end else if (FLUSH) begin
      D_INSTR <= NOP_INSTR;
      D_PC    <= 32'd0;
      D_PC8   <= 32'd0;
      D_VALID <= 1'b0;
    end else if (fd_load) begin
      D_INSTR   <= IM_OUT;
      D_PC      <= PC;
      D_PC8     <= PC + 32'd8;
      D_VALID   <= 1'b1;
      FETCH_CNT <= FETCH_CNT + 32'd1;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch (F) stage of the five-stage pipelined MIPS core.
- It is the initiator side of the instruction-memory interface. It owns the PC register and drives `PC` into the combinational IM. It latches the returned `IM_OUT` into the F/D pipeline register.
- Supports sequential fetch, branch/jump redirect from D, pipeline stall from the hazard unit, and F/D flush.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into F/D on reset or flush.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- STALL  in  1  hazard-unit stall; freezes PC and F/D register.
- FLUSH  in  1  clears F/D register to a bubble.
- REDIRECT  in  1  branch taken / j / jal / jr resolved in D.
- REDIRECT_PC  in  32  redirect target; bits [1:0] ignored.
- PC  out  32  current fetch address to IM.
- IM_OUT  in  32  instruction word from IM, combinational on `PC`.
- D_INSTR  out  32  F/D instruction.
- D_PC  out  32  F/D PC of that instruction.
- D_PC8  out  32  F/D PC+8 (jal/jalr link value).
- D_VALID  out  1  F/D holds a real fetched instruction (0 = bubble).
- FETCH_CNT  out  32  count of instructions latched into F/D (debug/perf).

Behaviour:
- Reset (synchronous, checked first):
  - PC <= RESET_PC; D_INSTR <= NOP_INSTR; D_PC <= 0; D_PC8 <= 0; D_VALID <= 0; FETCH_CNT <= 0.
  - Reset overrides every other input in the same cycle.
- PC register update, priority reset > STALL > REDIRECT > sequential:
  - STALL=1: PC holds. Any REDIRECT in the same cycle is ignored; D re-presents it next cycle.
  - REDIRECT=1, STALL=0: PC <= {REDIRECT_PC[31:2], 2'b00}.
  - Otherwise: PC <= PC + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- F/D register update, priority reset > FLUSH > STALL > load:
  - FLUSH=1: D_INSTR <= NOP_INSTR; D_PC <= 0; D_PC8 <= 0; D_VALID <= 0. Applies even when STALL=1. PC is still governed by the PC rules above, so with STALL=1 the same address is refetched next cycle.
  - STALL=1, FLUSH=0: all D_* outputs hold.
  - Load: D_INSTR <= IM_OUT; D_PC <= PC; D_PC8 <= PC + 8 (wraps); D_VALID <= 1.
- Delay slot:
  - REDIRECT does not squash the instruction fetched in the same cycle; it enters F/D normally.
  - Squashing is only via an explicit FLUSH.
- Latency:
  - `PC` is registered; `IM_OUT` returns combinationally in the same cycle.
  - The instruction at address A appears on D_INSTR one cycle after PC==A, if not stalled or flushed.
  - Redirect target appears on `PC` the cycle after REDIRECT is sampled, and on D_INSTR the cycle after that.
- FETCH_CNT:
  - Increments by 1 exactly on cycles where F/D loads (reset=0, FLUSH=0, STALL=0).
  - Wraps 32'hFFFF_FFFF -> 0.
- No combinational path from any input to `PC` or any D_* output; all outputs are registers.
- X-safety: if `IM_OUT` is X on a load cycle, X propagates to D_INSTR only; PC sequencing is unaffected.

Test Plan:
1. Reset, then 4 free-running cycles with IM returning 32'h2408_0001 at 0x3000, 32'h2409_0002 at 0x3004, …
   -> PC = 0x3000, 0x3004, 0x3008, 0x300C.
   -> D_INSTR lags PC by 1 cycle; first D_PC = 0x3000, D_PC8 = 0x3008, D_VALID = 1, FETCH_CNT = 1.
2. At PC = 0x3008, assert STALL for 2 cycles.
   -> PC holds 0x3008 and D_* hold both cycles; FETCH_CNT unchanged.
   -> After release, PC = 0x300C and D_PC = 0x3008.
3. At PC = 0x3010, assert REDIRECT with REDIRECT_PC = 0x0000_3403.
   -> Next PC = 0x3400 (low bits cleared).
   -> D_PC = 0x3010 (delay slot kept); following D_PC = 0x3400.
4. STALL=1, REDIRECT=1 (target 0x3800) and FLUSH=1 in the same cycle.
   -> PC holds; D_INSTR = 0, D_VALID = 0, FETCH_CNT unchanged.
   -> Next cycle with STALL=0, REDIRECT=1 -> PC = 0x3800.
5. Redirect to 0xFFFF_FFFC, then free-run.
   -> PC = 0xFFFF_FFFC then 0x0000_0000.
   -> D_PC8 for the 0xFFFF_FFFC instruction = 0x0000_0004.
6. Assert reset mid-stream together with STALL=1 and REDIRECT=1.
   -> Next edge: PC = 0x3000, D_INSTR = 0, D_VALID = 0, FETCH_CNT = 0.
